// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned NREG      = 32;
  localparam int unsigned STARVE_CW = 4;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MC   = 2'd2
  } gnt_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register owed by the
// multi-cycle unit, with a three-port busy lookup for the decode stage.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] q0_idx,
  input  logic [REG_AW-1:0] q1_idx,
  input  logic [REG_AW-1:0] q2_idx,
  output logic              busy
);

  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_sb_d;

  // Next vector: clear first so a same-cycle set of the same bit wins.
  always_comb begin
    w_sb_d = r_sb;
    if (clr_en) w_sb_d[clr_idx] = 1'b0;
    if (set_en) w_sb_d[set_idx] = 1'b1;
    w_sb_d[0] = 1'b0;  // x0 is never owed
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sb <= '0;
    else     r_sb <= w_sb_d;
  end

  // Bit 0 is held at zero, so register 0 always reads as not busy.
  always_comb busy = r_sb[q0_idx] | r_sb[q1_idx] | r_sb[q2_idx];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback stage and a
// multi-cycle unit, with starvation guard and busy-register scoreboard.
// Optional macro RF_WB_STATS_EN adds mc_block_cnt / force_cnt statistics.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned Width     = 32,
  parameter int unsigned StarveMax = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_a3,
  input  logic [Width-1:0]  pipe_wd,
  output logic              pipe_stall,
  input  logic              mc_valid,
  input  logic [REG_AW-1:0] mc_a3,
  input  logic [Width-1:0]  mc_wd,
  output logic              mc_ready,
  input  logic              iss_valid,
  input  logic              iss_mc,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              busy_hazard,
  output logic [REG_AW-1:0] a3,
  output logic              we3,
  output logic [Width-1:0]  wd3
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0]       mc_block_cnt,
  output logic [15:0]       force_cnt
`endif
);

  localparam logic [STARVE_CW-1:0] StarveLast = STARVE_CW'(StarveMax - 1);
  localparam logic [STARVE_CW-1:0] CntMax     = '1;

  logic [STARVE_CW-1:0] r_starve_cnt;
  logic                 r_force;
  gnt_e                 w_gnt;
  logic                 w_mc_hs;
  logic                 w_blocked;

  // Grant: pipeline normally wins; a pending force hands the port to mc.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!rst) begin
      if (r_force && mc_valid) w_gnt = GNT_MC;
      else if (pipe_we)        w_gnt = GNT_PIPE;
      else if (mc_valid)       w_gnt = GNT_MC;
    end
  end

  // Write-port mux and handshake outputs; we3 suppressed for x0.
  always_comb begin
    a3  = '0;
    wd3 = '0;
    unique case (w_gnt)
      GNT_PIPE: begin a3 = pipe_a3; wd3 = pipe_wd; end
      GNT_MC:   begin a3 = mc_a3;   wd3 = mc_wd;   end
      default:  ;
    endcase
    we3        = (w_gnt != GNT_NONE) && (a3 != '0);
    mc_ready   = (w_gnt == GNT_MC);
    pipe_stall = !rst && r_force && mc_valid && pipe_we;
  end

  assign w_mc_hs   = mc_valid & mc_ready;
  assign w_blocked = mc_valid & ~mc_ready;

  // Starvation counter and registered force flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_force      <= 1'b0;
    end else if (w_mc_hs) begin
      r_starve_cnt <= '0;
      r_force      <= 1'b0;
    end else if (!mc_valid) begin
      r_starve_cnt <= '0;
    end else if (w_blocked) begin
      if (r_starve_cnt != CntMax) r_starve_cnt <= r_starve_cnt + 1'b1;
      if (r_starve_cnt >= StarveLast) r_force <= 1'b1;
    end
  end

  rf_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_valid & iss_mc),
    .set_idx (iss_rd),
    .clr_en  (w_mc_hs),
    .clr_idx (mc_a3),
    .q0_idx  (chk_rs1),
    .q1_idx  (chk_rs2),
    .q2_idx  (chk_rd),
    .busy    (busy_hazard)
  );

  // Decode stalls on busy registers, so a granted pipeline write to one is a bug upstream.
  a_pipe_write_busy : assert property (@(posedge clk) disable iff (rst)
    !((w_gnt == GNT_PIPE) && (pipe_a3 != '0) && u_sb.r_sb[pipe_a3]));

`ifdef RF_WB_STATS_EN
  logic [15:0] r_mc_block_cnt;
  logic [15:0] r_force_cnt;

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mc_block_cnt <= '0;
      r_force_cnt    <= '0;
    end else begin
      if (w_blocked && r_mc_block_cnt != 16'hFFFF) r_mc_block_cnt <= r_mc_block_cnt + 16'd1;
      if (r_force && w_mc_hs && r_force_cnt != 16'hFFFF) r_force_cnt <= r_force_cnt + 16'd1;
    end
  end

  assign mc_block_cnt = r_mc_block_cnt;
  assign force_cnt    = r_force_cnt;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port (a3/we3/wd3) in the pipeline core.
- Shares that port between two requesters:
  - the in-order pipeline writeback stage, which normally has priority;
  - a multi-cycle execution unit (mul/div), which uses a valid/ready handshake.
- Keeps a scoreboard of destination registers owed by the multi-cycle unit and raises an issue hazard.
- Has a starvation guard that briefly stalls the pipeline writeback so the multi-cycle unit cannot starve.

Parameters:
- Width, 32, data width of register-file write data.
- StarveMax, 4, consecutive blocked cycles of mc_valid before the multi-cycle unit is force-granted (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pipe_we  input  1  pipeline writeback write request.
- pipe_a3  input  5  pipeline writeback destination register.
- pipe_wd  input  Width  pipeline writeback data.
- pipe_stall  output  1  pipeline must hold its writeback stage this cycle.
- mc_valid  input  1  multi-cycle unit result valid.
- mc_a3  input  5  multi-cycle result destination register.
- mc_wd  input  Width  multi-cycle result data.
- mc_ready  output  1  multi-cycle result is accepted this cycle.
- iss_valid  input  1  an instruction issues this cycle.
- iss_mc  input  1  the issuing instruction goes to the multi-cycle unit.
- iss_rd  input  5  destination register of the issuing instruction.
- chk_rs1, chk_rs2, chk_rd  input  5 each  registers of the instruction in decode.
- busy_hazard  output  1  the decode instruction touches a register owed by the multi-cycle unit.
- a3  output  5  register-file write address.
- we3  output  1  register-file write enable.
- wd3  output  Width  register-file write data.

Behaviour:
- Reset (asynchronous): scoreboard = 0, starve_cnt = 0, force = 0.
  - Outputs during reset: we3 = 0, mc_ready = 0, pipe_stall = 0, busy_hazard = 0, a3 = 0, wd3 = 0.
- The write port is combinational. The register file captures a3/we3/wd3 on the same clk edge, so write latency is 0 cycles.
- Grant rules, evaluated each cycle:
  - force = 0: the pipeline wins.
    - mc_ready = mc_valid & ~pipe_we.
    - pipe_stall = 0.
  - force = 1: the multi-cycle unit wins.
    - mc_ready = mc_valid.
    - pipe_stall = pipe_we & mc_valid.
    - The pipeline holds its pipe_* inputs stable and retries next cycle.
  - Write port mux: the granted source drives a3/wd3.
  - With no grant: a3 = 0, wd3 = 0, we3 = 0.
- x0 handling:
  - we3 is forced to 0 whenever the selected a3 == 0.
  - The handshake still completes: mc_ready asserts normally, so the unit is not hung.
- Starvation counter (4 bits):
  - Increments when mc_valid & ~mc_ready.
  - Clears to 0 on a mc handshake or when mc_valid = 0.
  - force is registered: it sets when the counter reaches StarveMax-1 with mc still blocked, and clears after one mc handshake.
  - Result: after StarveMax blocked cycles the multi-cycle unit wins on the next cycle, exactly once.
- Scoreboard (32 bits):
  - Set: bit iss_rd is set when iss_valid & iss_mc & iss_rd != 0.
  - Clear: bit mc_a3 is cleared on a mc handshake.
  - Set and clear of the same bit in one cycle: set wins, so the bit stays 1.
  - Bit 0 is never set.
- busy_hazard = sb[chk_rs1] | sb[chk_rs2] | sb[chk_rd].
  - Combinational from the registered scoreboard.
  - Covers RAW (rs1/rs2) and WAW (rd).
  - Register 0 always reads as not busy.
- A pipeline write to a register whose scoreboard bit is set is illegal, since decode stalls on busy_hazard.
  - An assertion flags it.
  - RTL behaviour in that case: the write proceeds and the scoreboard is unchanged.
- Reset asserted mid-operation: all state clears immediately; any in-flight mc result is neither written nor acknowledged.

Optional Feature:
- Macro: RF_WB_STATS_EN.
- When defined, adds two outputs:
  - mc_block_cnt (16-bit): counts cycles with mc_valid & ~mc_ready; saturates at 0xFFFF; cleared by rst.
  - force_cnt (16-bit): counts forced grants; saturates at 0xFFFF; cleared by rst.
- When undefined: the ports and counters are absent, and the core behaviour is identical.

Decomposition:
- Shared package contents:
  - REG_AW = 5, NREG = 32;
  - grant encoding: GNT_NONE, GNT_PIPE, GNT_MC;
  - STARVE_CW = 4.
- Sub-module rf_scoreboard:
  - Contains the 32-bit set/clear vector and the three-port busy lookup.
  - Ports: clk, rst, set_en, set_idx, clr_en, clr_idx, three query indices, busy.

Test Plan:
- Conflict, pipeline wins: pipe_we=1, pipe_a3=5, pipe_wd=0x11 together with mc_valid=1, mc_a3=6, mc_wd=0x22, force=0 → we3=1, a3=5, wd3=0x11, mc_ready=0, pipe_stall=0.
- Starvation: hold pipe_we=1 and mc_valid=1 (mc_a3=6) with StarveMax=4 → mc_ready=0 for cycles 1–4; in cycle 5 a3=6, wd3=mc_wd, pipe_stall=1, mc_ready=1; cycle 6 returns to the pipeline.
- Scoreboard: issue iss_mc with iss_rd=7, then chk_rs1=7 → busy_hazard=1 from the next cycle; mc handshake with mc_a3=7 → busy_hazard=0 the cycle after.
- Same-cycle set and clear: mc handshake on rd=9 while iss_mc issues rd=9 → sb[9] stays 1 and busy_hazard stays 1.
- x0: mc_valid=1, mc_a3=0, pipe_we=0 → mc_ready=1, we3=0, and no scoreboard bit changes.
- Reset: rst pulsed mid-starvation (cnt=3, sb[4]=1) → we3=0, busy_hazard=0, force=0 immediately; after release, a new conflict needs the full StarveMax cycles before mc is force-granted.
